// File: rtl/id_stage.sv
// Instruction-decode stage: holds the IR, the 8-entry register file and the ID/EX register,
// detects load-use and branch-operand hazards, and resolves BZ branches in ID.
module id_stage #(
  parameter int REG_WID = 16,
  parameter int IMM_WID = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        instruction,
  input  logic               wb_we,
  input  logic [2:0]         wb_rd,
  input  logic [REG_WID-1:0] wb_data,
  output logic               enable1,
  output logic               branch_taken,
  output logic [IMM_WID-1:0] branch_offse,
  output logic [2:0]         ex_alu_op,
  output logic [REG_WID-1:0] ex_a,
  output logic [REG_WID-1:0] ex_b,
  output logic [REG_WID-1:0] ex_st_data,
  output logic [2:0]         ex_rd,
  output logic               ex_reg_we,
  output logic               ex_mem_rd,
  output logic               ex_mem_wr
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SL   = 4'h6;
  localparam logic [3:0] OP_SR   = 4'h7;
  localparam logic [3:0] OP_SRU  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SL  = 3'd5;
  localparam logic [2:0] ALU_SR  = 3'd6;
  localparam logic [2:0] ALU_SRU = 3'd7;

  logic [15:0]        ir;
  logic [REG_WID-1:0] rf [8];

  logic [3:0]         op;
  logic [2:0]         f_rd, f_rs1, f_rs2;
  logic [REG_WID-1:0] imm_ext;
  logic [REG_WID-1:0] rd_val, rs1_val, rs2_val;

  logic is_r, is_addi, is_ld, is_st, is_bz;
  logic uses_rs1, uses_rs2, uses_rd;
  logic load_use, br_dep, stall;

  logic [2:0]         nx_alu_op;
  logic [REG_WID-1:0] nx_a, nx_b, nx_st_data;
  logic [2:0]         nx_rd;
  logic               nx_reg_we, nx_mem_rd, nx_mem_wr;

  // Register read with write-through from WB; index 0 is hardwired to zero.
  function automatic logic [REG_WID-1:0] read_port(input logic [2:0] idx,
                                                   input logic [REG_WID-1:0] stored,
                                                   input logic we,
                                                   input logic [2:0] wr_idx,
                                                   input logic [REG_WID-1:0] wr_data);
    if (idx == 3'd0)
      return '0;
    else if (we && (wr_idx == idx))
      return wr_data;
    else
      return stored;
  endfunction

  assign op      = ir[15:12];
  assign f_rd    = ir[11:9];
  assign f_rs1   = ir[8:6];
  assign f_rs2   = ir[5:3];
  assign imm_ext = {{(REG_WID-IMM_WID){ir[IMM_WID-1]}}, ir[IMM_WID-1:0]};

  assign rd_val  = read_port(f_rd,  rf[f_rd],  wb_we, wb_rd, wb_data);
  assign rs1_val = read_port(f_rs1, rf[f_rs1], wb_we, wb_rd, wb_data);
  assign rs2_val = read_port(f_rs2, rf[f_rs2], wb_we, wb_rd, wb_data);

  always_comb begin
    is_r    = (op >= OP_ADD) && (op <= OP_SRU);
    is_addi = (op == OP_ADDI);
    is_ld   = (op == OP_LD);
    is_st   = (op == OP_ST);
    is_bz   = (op == OP_BZ);
  end

  // The rd field is a source for ST (store data) and BZ (tested register).
  assign uses_rs1 = is_r | is_addi | is_ld | is_st;
  assign uses_rs2 = is_r;
  assign uses_rd  = is_st | is_bz;

  assign load_use = ex_mem_rd && (ex_rd != 3'd0) &&
                    ((uses_rs1 && (ex_rd == f_rs1)) ||
                     (uses_rs2 && (ex_rd == f_rs2)) ||
                     (uses_rd  && (ex_rd == f_rd)));
  assign br_dep   = is_bz && ex_reg_we && (f_rd != 3'd0) && (ex_rd == f_rd);
  assign stall    = load_use | br_dep;

  assign enable1      = ~stall;
  assign branch_taken = is_bz && !stall && (rd_val == '0);
  assign branch_offse = is_bz ? ir[IMM_WID-1:0] : '0;

  always_comb begin
    nx_alu_op  = ALU_ADD;
    nx_a       = '0;
    nx_b       = '0;
    nx_st_data = '0;
    nx_rd      = 3'd0;
    nx_reg_we  = 1'b0;
    nx_mem_rd  = 1'b0;
    nx_mem_wr  = 1'b0;
    if (!stall) begin
      if (is_r) begin
        nx_a      = rs1_val;
        nx_b      = rs2_val;
        nx_rd     = f_rd;
        nx_reg_we = 1'b1;
        case (op)
          OP_SUB:  nx_alu_op = ALU_SUB;
          OP_AND:  nx_alu_op = ALU_AND;
          OP_OR:   nx_alu_op = ALU_OR;
          OP_XOR:  nx_alu_op = ALU_XOR;
          OP_SL:   nx_alu_op = ALU_SL;
          OP_SR:   nx_alu_op = ALU_SR;
          OP_SRU:  nx_alu_op = ALU_SRU;
          default: nx_alu_op = ALU_ADD;
        endcase
      end else if (is_addi || is_ld) begin
        nx_a      = rs1_val;
        nx_b      = imm_ext;
        nx_rd     = f_rd;
        nx_reg_we = 1'b1;
        nx_mem_rd = is_ld;
      end else if (is_st) begin
        nx_a       = rs1_val;
        nx_b       = imm_ext;
        nx_st_data = rd_val;
        nx_mem_wr  = 1'b1;
      end
      // NOP, BZ and undefined opcodes leave the bubble in place.
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ir <= '0;
    else if (branch_taken)
      ir <= '0;
    else if (enable1)
      ir <= instruction;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++)
        rf[i] <= '0;
    end else if (wb_we && (wb_rd != 3'd0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_alu_op  <= ALU_ADD;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_st_data <= '0;
      ex_rd      <= 3'd0;
      ex_reg_we  <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
    end else begin
      ex_alu_op  <= nx_alu_op;
      ex_a       <= nx_a;
      ex_b       <= nx_b;
      ex_st_data <= nx_st_data;
      ex_rd      <= nx_rd;
      ex_reg_we  <= nx_reg_we;
      ex_mem_rd  <= nx_mem_rd;
      ex_mem_wr  <= nx_mem_wr;
    end
  end

endmodule
